// File: rtl/freepdk45_sram_1rw_port_ctrl.sv
// Initiator-side port controller for a single-port 1RW OpenRAM macro: zero-clears the
// array after reset, then turns valid/ready requests into registered macro pin activity.
module freepdk45_sram_1rw_port_ctrl #(
   parameter int unsigned DATA_WIDTH = 88,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned NUM_WMASKS = 4,
   parameter int unsigned RSP_DEPTH  = 4,
   parameter bit          INIT_EN    = 1'b1
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);
   localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned SWEEP_W   = ADDR_WIDTH + 1;
   localparam int unsigned PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);
   localparam int unsigned USE_W     = CNT_W + 1;

   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

   state_t                state, state_n;
   logic [SWEEP_W-1:0]    sweep_cnt, sweep_n;
   logic                  sweep_done;
   logic                  csb_n, web_n;
   logic [NUM_WMASKS-1:0] wmask_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [DATA_WIDTH-1:0] din_n;
   logic                  accept, push, pop;
   logic                  rd_p0, rd_p1, rd_p0_n;
   logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [CNT_W-1:0]      count, count_n;
   logic [USE_W-1:0]      used_n;
   logic [DATA_WIDTH-1:0] head_n;
   logic                  req_ready_n;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign sweep_done = (sweep_cnt == SWEEP_W'(RAM_DEPTH));
   assign accept     = req_valid && req_ready;

   // State register
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) state <= INIT_EN ? ST_INIT : ST_RUN;
      else      state <= state_n;
   end

   // Next state
   always_comb begin
      state_n = state;
      case (state)
         ST_INIT: if (sweep_done) state_n = ST_RUN;
         ST_RUN:  state_n = ST_RUN;
      endcase
   end

   // Next pin values: sweep writes during INIT, accepted requests during RUN
   always_comb begin
      csb_n   = 1'b1;
      web_n   = 1'b1;
      wmask_n = wmask0;
      addr_n  = addr0;
      din_n   = din0;
      sweep_n = sweep_cnt;
      rd_p0_n = 1'b0;
      case (state)
         ST_INIT: begin
            if (!sweep_done) begin
               csb_n   = 1'b0;
               web_n   = 1'b0;
               wmask_n = '1;
               din_n   = '0;
               addr_n  = sweep_cnt[ADDR_WIDTH-1:0];
               sweep_n = sweep_cnt + SWEEP_W'(1);
            end
         end
         ST_RUN: begin
            if (accept) begin
               csb_n   = 1'b0;
               web_n   = ~req_we;
               addr_n  = req_addr;
               din_n   = req_wdata;
               wmask_n = req_we ? req_wmask : '0;
               rd_p0_n = ~req_we;
            end
         end
      endcase
   end

   // Response buffer bookkeeping; the head entry is pre-computed so rsp_rdata is a flop
   always_comb begin
      push     = rd_p1;
      pop      = rsp_valid && rsp_ready;
      wr_ptr_n = push ? ptr_inc(wr_ptr) : wr_ptr;
      rd_ptr_n = pop  ? ptr_inc(rd_ptr) : rd_ptr;
      count_n  = count + CNT_W'(push) - CNT_W'(pop);
      used_n   = USE_W'(count_n) + USE_W'(rd_p0_n) + USE_W'(rd_p0);
      head_n   = (push && (wr_ptr == rd_ptr_n)) ? dout0 : fifo_mem[rd_ptr_n];
      req_ready_n = (state_n == ST_RUN) && (used_n < USE_W'(RSP_DEPTH));
   end

   always_ff @(posedge clk0) begin
      if (push) fifo_mem[wr_ptr] <= dout0;
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         csb0      <= 1'b1;
         web0      <= 1'b1;
         wmask0    <= '0;
         addr0     <= '0;
         din0      <= '0;
         sweep_cnt <= '0;
         rd_p0     <= 1'b0;
         rd_p1     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         csb0      <= csb_n;
         web0      <= web_n;
         wmask0    <= wmask_n;
         addr0     <= addr_n;
         din0      <= din_n;
         sweep_cnt <= sweep_n;
         rd_p0     <= rd_p0_n;
         rd_p1     <= rd_p0;
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         count     <= count_n;
         rsp_valid <= (count_n != '0);
         rsp_rdata <= head_n;
         req_ready <= req_ready_n;
         init_done <= (state_n == ST_RUN);
      end
   end

endmodule

// File: tb/tb_freepdk45_sram_1rw_port_ctrl.sv
// Bench for freepdk45_sram_1rw_port_ctrl: behavioural 1RW macro on the pins, reference
// memory plus response queue as the scoreboard.
module tb_freepdk45_sram_1rw_port_ctrl;
   localparam int unsigned DW    = 88;
   localparam int unsigned AW    = 6;
   localparam int unsigned NM    = 4;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned LANE  = DW / NM;

   logic          clk0 = 1'b0;
   logic          rst0 = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [NM-1:0] req_wmask = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          init_done, csb0, web0;
   logic [NM-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0 = '0;

   freepdk45_sram_1rw_port_ctrl dut (
      .clk0(clk0), .rst0(rst0),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .init_done(init_done), .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0), .dout0(dout0)
   );

   always #5 clk0 = ~clk0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [NM-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < NM; i++) if (m[i]) r[i*LANE +: LANE] = d[i*LANE +: LANE];
      return r;
   endfunction

   // Macro model: pins sampled on posedge, array access on the following negedge
   logic [DW-1:0] mem [DEPTH];
   logic          m_csb = 1'b1, m_web = 1'b1;
   logic [NM-1:0] m_wmask = '0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din = '0;
   always @(posedge clk0) begin
      m_csb <= csb0; m_web <= web0; m_wmask <= wmask0; m_addr <= addr0; m_din <= din0;
   end
   always @(negedge clk0) begin
      if (!m_csb && !m_web) mem[m_addr] <= merge(mem[m_addr], m_din, m_wmask);
      if (!m_csb && m_web)  dout0 <= mem[m_addr];
   end

   int            checks = 0, passes = 0, pop_count = 0;
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] sb [$];
   bit            c_acc, c_pop, c_unexp;
   logic [DW-1:0] c_pdata, c_exp;

   task automatic set_req(input bit v, input bit we, input int a, input logic [DW-1:0] d,
                          input logic [NM-1:0] m);
      req_valid = v; req_we = we; req_addr = AW'(a); req_wdata = d; req_wmask = m;
   endtask

   // One clock: record handshakes into the model/scoreboard, then advance past the edge
   task automatic cycle();
      c_acc = req_valid && req_ready;
      c_pop = rsp_valid && rsp_ready;
      c_pdata = rsp_rdata; c_exp = '0; c_unexp = 1'b0;
      if (c_acc) begin
         if (req_we) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
         else        sb.push_back(ref_mem[req_addr]);
      end
      if (c_pop) begin
         pop_count++;
         if (sb.size() == 0) c_unexp = 1'b1;
         else                c_exp = sb.pop_front();
      end
      @(posedge clk0); #1;
   endtask

   task automatic drain(input string name);
      set_req(0, 0, 0, '0, '0);
      rsp_ready = 1'b1;
      repeat (12) begin
         cycle();
         if (c_pop) begin
            checks++;
            if (c_unexp || c_pdata !== c_exp)
               $display("FAIL %s_data: got %h expected %h (unexpected=%0b)", name, c_pdata, c_exp, c_unexp);
            else passes++;
         end
      end
      checks++;
      if (sb.size() != 0) $display("FAIL %s_lost: %0d responses outstanding, expected 0", name, sb.size());
      else passes++;
   endtask

   task automatic test_reset();
      set_req(0, 0, 0, '0, '0);
      rsp_ready = 1'b0;
      #1 rst0 = 1'b1;
      @(posedge clk0); #1;
      checks++;
      if ({csb0, web0} !== 2'b11) $display("FAIL reset_csb_web: got %b expected 11", {csb0, web0});
      else passes++;
      checks++;
      if ({wmask0, addr0, din0} !== '0) $display("FAIL reset_pins: got %h expected 0", {wmask0, addr0, din0});
      else passes++;
      checks++;
      if ({req_ready, rsp_valid, init_done} !== 3'b000)
         $display("FAIL reset_flags: got %b expected 000", {req_ready, rsp_valid, init_done});
      else passes++;
      checks++;
      if (rsp_rdata !== '0) $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
      else passes++;
   endtask

   // Releases reset (held high on entry) and follows the zero-clear sweep edge by edge
   task automatic test_init_sweep(input string name);
      logic [102:0] got, exp;
      rst0 = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         @(posedge clk0); #1;
         got = {csb0, web0, wmask0, addr0, din0, init_done, req_ready, rsp_valid};
         exp = {1'b0, 1'b0, 4'hF, AW'(k - 1), DW'(0), 3'b000};
         checks++;
         if (got !== exp) $display("FAIL %s_edge%0d: got %h expected %h", name, k, got, exp);
         else passes++;
      end
      @(posedge clk0); #1;
      checks++;
      if ({csb0, init_done, req_ready, rsp_valid} !== 4'b1110)
         $display("FAIL %s_done: got %b expected 1110", name, {csb0, init_done, req_ready, rsp_valid});
      else passes++;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      sb.delete();
   endtask

   task automatic test_read_write();
      logic [DW-1:0] pat, mexp;
      int lat;
      int zaddr [3] = '{0, 33, 63};
      pat = {11{8'hA5}};
      mexp = pat; mexp[21:0] = '1; mexp[65:44] = '1;
      rsp_ready = 1'b1;
      foreach (zaddr[i]) begin
         set_req(1, 0, zaddr[i], '0, '0);
         cycle();
         checks++;
         if (!c_acc) $display("FAIL zero_read_accept: req_ready=%b expected 1", c_acc);
         else passes++;
      end
      drain("zero_read");
      set_req(1, 1, 5, pat, 4'hF);
      cycle();
      set_req(1, 0, 5, '0, '0);
      cycle();
      checks++;
      if (!c_acc) $display("FAIL raw_read_accept: req_ready=%b expected 1", c_acc);
      else passes++;
      set_req(0, 0, 0, '0, '0);
      lat = 0;
      while (!rsp_valid && lat < 8) begin cycle(); lat++; end
      checks++;
      if (lat != 2) $display("FAIL read_latency: got %0d edges expected 2", lat);
      else passes++;
      checks++;
      if (rsp_rdata !== pat) $display("FAIL raw_data: got %h expected %h", rsp_rdata, pat);
      else passes++;
      drain("raw");
      set_req(1, 1, 5, '1, 4'b0101);
      cycle();
      set_req(1, 0, 5, '0, '0);
      cycle();
      set_req(0, 0, 0, '0, '0);
      lat = 0;
      while (!rsp_valid && lat < 8) begin cycle(); lat++; end
      checks++;
      if (rsp_rdata !== mexp) $display("FAIL masked_data: got %h expected %h", rsp_rdata, mexp);
      else passes++;
      drain("masked");
   endtask

   task automatic test_backpressure();
      int n_acc, next, pops0;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         set_req(1, 1, i, DW'({$urandom(), $urandom(), $urandom()}), 4'hF);
         cycle();
         if (c_acc) n_acc++;
      end
      checks++;
      if (n_acc != 10) $display("FAIL bp_writes: got %0d accepts expected 10", n_acc);
      else passes++;
      rsp_ready = 1'b0;
      pops0 = pop_count;
      n_acc = 0; next = 0;
      for (int c = 0; c < 10; c++) begin
         set_req(1, 0, next, '0, '0);
         cycle();
         if (c_acc) begin n_acc++; next++; end
      end
      checks++;
      if (n_acc != 4) $display("FAIL bp_accepts: got %0d expected 4", n_acc);
      else passes++;
      checks++;
      if (req_ready !== 1'b0) $display("FAIL bp_ready: got %b expected 0", req_ready);
      else passes++;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && next < 10; c++) begin
         set_req(1, 0, next, '0, '0);
         cycle();
         if (c_acc) next++;
         if (c_pop) begin
            checks++;
            if (c_unexp || c_pdata !== c_exp)
               $display("FAIL bp_data: got %h expected %h (unexpected=%0b)", c_pdata, c_exp, c_unexp);
            else passes++;
         end
      end
      checks++;
      if (next != 10) $display("FAIL bp_stall: issued %0d reads expected 10", next);
      else passes++;
      drain("bp");
      checks++;
      if (pop_count - pops0 != 10) $display("FAIL bp_count: got %0d responses expected 10", pop_count - pops0);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [25:0] rv;
      int n_acc;
      rsp_ready = 1'b1;
      n_acc = 0; rv = '0;
      for (int j = 0; j < 26; j++) begin
         if (j < 20) set_req(1, 0, int'($urandom_range(DEPTH - 1)), '0, '0);
         else        set_req(0, 0, 0, '0, '0);
         cycle();
         if (c_acc) n_acc++;
         if (c_pop) begin
            checks++;
            if (c_unexp || c_pdata !== c_exp)
               $display("FAIL b2b_data: got %h expected %h (unexpected=%0b)", c_pdata, c_exp, c_unexp);
            else passes++;
         end
         rv[j] = rsp_valid;
      end
      checks++;
      if (n_acc != 20) $display("FAIL b2b_accepts: got %0d expected 20", n_acc);
      else passes++;
      checks++;
      if (rv !== 26'h3FFFFC) $display("FAIL b2b_valid: got %h expected 3ffffc", rv);
      else passes++;
      drain("b2b");
   endtask

   task automatic test_async_reset();
      set_req(1, 1, 7, {11{8'h3C}}, 4'hF);
      cycle();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin set_req(1, 0, i, '0, '0); cycle(); end
      #2;
      checks++;
      if ({csb0, rsp_valid} !== 2'b01) $display("FAIL pre_reset: csb0,rsp_valid got %b expected 01", {csb0, rsp_valid});
      else passes++;
      rst0 = 1'b1;
      #1;
      checks++;
      if ({csb0, web0, rsp_valid, req_ready} !== 4'b1100)
         $display("FAIL async_reset: got %b expected 1100", {csb0, web0, rsp_valid, req_ready});
      else passes++;
      sb.delete();
      set_req(0, 0, 0, '0, '0);
      @(posedge clk0); #1;
      test_init_sweep("reinit");
      rsp_ready = 1'b1;
      set_req(1, 0, 7, '0, '0); cycle();
      set_req(1, 0, 0, '0, '0); cycle();
      drain("post_reset");
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = DW'({$urandom(), $urandom(), $urandom()});
         ref_mem[i] = '0;
      end
      test_reset();
      test_init_sweep("init");
      test_read_write();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

endmodule
